// File: rtl/mpmc10_wdf_burst_gen.sv
// Purpose : multi-beat write-data burst engine feeding the MIG app_wdf_* write-data FIFO.
// Latency : beat accepted from upstream in cycle k appears on app_wdf_wren in cycle k+1; done pulses one cycle after the final transfer.
// Backpr. : app_wdf_rdy low holds the output beat bit-stable and drops din_ready; the output register refills in the same cycle it drains.
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   start, beats                 burst request (IDLE only) and beat count (0 -> 1, clamped to MAX_BEATS)
//   din_valid/ready/data/mask    upstream beat buffer handshake
//   app_wdf_rdy/wren/end/data/mask  MIG UI write-data channel
//   busy, done, start_err        burst status
module mpmc10_wdf_burst_gen #(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BEATS  = 8,
    parameter int CW         = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [CW-1:0]           beats,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [DATA_WIDTH-1:0]   din_data,
    input  logic [DATA_WIDTH/8-1:0] din_mask,
    input  logic                    app_wdf_rdy,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    busy,
    output logic                    done,
    output logic                    start_err
);

    localparam int            MW    = DATA_WIDTH / 8;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] rem_in;   // beats still to pull from upstream
    logic [CW-1:0] rem_out;  // beats still to hand to the MIG
    logic [CW-1:0] n_eff;
    logic          accept;
    logic          xfer;

    // Effective burst length: zero means one beat, oversize requests clamp.
    always_comb begin
        n_eff = beats;
        if (beats == '0) begin
            n_eff = ONE;
        end else if (beats > MAX_C) begin
            n_eff = MAX_C;
        end
    end

    // The output register can take a new beat when it is empty or draining
    // this cycle; din_valid is deliberately kept out of this path.
    assign din_ready = (state == BURST) && (rem_in != '0) && (!app_wdf_wren || app_wdf_rdy);
    assign accept    = din_valid && din_ready;
    assign xfer      = app_wdf_wren && app_wdf_rdy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            rem_in       <= '0;
            rem_out      <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            start_err    <= 1'b0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;

            if (start && (state != IDLE)) begin
                start_err <= 1'b1;
            end

            // Output beat register: a new accept overwrites a beat that is
            // transferring this same cycle, so back-to-back beats have no bubble.
            if (accept) begin
                app_wdf_data <= din_data;
                app_wdf_mask <= din_mask;
                app_wdf_wren <= 1'b1;
                app_wdf_end  <= (rem_in == ONE);
            end else if (xfer) begin
                app_wdf_wren <= 1'b0;
                app_wdf_end  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        rem_in  <= n_eff;
                        rem_out <= n_eff;
                        busy    <= 1'b1;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    if (accept && (rem_in != '0)) begin
                        rem_in <= rem_in - ONE;
                        if (rem_in == ONE) begin
                            state <= DRAIN;
                        end
                    end
                    if (xfer && (rem_out != '0)) begin
                        rem_out <= rem_out - ONE;
                    end
                end
                DRAIN: begin
                    // The last beat is always in the output register here.
                    if (xfer && (rem_out != '0)) begin
                        rem_out <= rem_out - ONE;
                        if (rem_out == ONE) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic [MW-1:0] unused_mw;
    assign unused_mw = '0;

endmodule

// File: tb/tb_mpmc10_wdf_burst_gen.sv
module tb_mpmc10_wdf_burst_gen;

    localparam int DW = 128;
    localparam int MB = 8;
    localparam int CW = $clog2(MB + 1);
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [CW-1:0] beats;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] din_data;
    logic [MW-1:0] din_mask;
    logic          app_wdf_rdy;
    logic          wren;
    logic          wend;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          busy;
    logic          done;
    logic          start_err;

    mpmc10_wdf_burst_gen #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .beats       (beats),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .din_data    (din_data),
        .din_mask    (din_mask),
        .app_wdf_rdy (app_wdf_rdy),
        .app_wdf_wren(wren),
        .app_wdf_end (wend),
        .app_wdf_data(wdata),
        .app_wdf_mask(wmask),
        .busy        (busy),
        .done        (done),
        .start_err   (start_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Upstream beat source: beats are offered in order and must reach the MIG in order.
    logic [DW-1:0] src_d [0:15];
    logic [MW-1:0] src_m [0:15];

    // Observations of one burst, summarised for the scenario tasks.
    int r_n, r_xfers, r_accepts, r_ends, r_end_last, r_data_errs, r_hold_errs;
    int r_done_cyc, r_first_wren, r_serr_cnt, r_serr_cyc, r_rdy_cnt, r_rdy_first;
    int r_busy_bad, r_wren_pulses;
    bit r_timeout;

    // Drives one burst cycle by cycle (cycle 0 = start cycle) and records what
    // the MIG side saw. vmode: 0 valid always, 1 valid on odd cycles, 2 random.
    // rmode: 0 rdy always, 1 rdy low in cycles 3..5, 2 random.
    task automatic run_burst(input int req, input int vmode, input int rmode,
                             input int err_at, input bit seq, input bit pre_started);
        int idx;
        logic pw, pe, prdy;
        logic [DW-1:0] pd;
        logic [MW-1:0] pm;
        r_n = (req == 0) ? 1 : ((req > MB) ? MB : req);
        for (int i = 0; i < 16; i++) begin
            src_d[i] = seq ? DW'(i + 1) : {$urandom, $urandom, $urandom, $urandom};
            src_m[i] = seq ? MW'(i) : MW'($urandom);
        end
        r_xfers = 0; r_accepts = 0; r_ends = 0; r_end_last = 0; r_data_errs = 0;
        r_hold_errs = 0; r_done_cyc = -1; r_first_wren = -1; r_serr_cnt = 0;
        r_serr_cyc = -1; r_rdy_cnt = 0; r_rdy_first = -1; r_busy_bad = 0;
        r_wren_pulses = 0; r_timeout = 0;
        idx = 0; pw = 0; pe = 0; prdy = 1; pd = '0; pm = '0;
        for (int c = 0; c < 200; c++) begin
            if (!(c == 0 && pre_started)) begin
                @(posedge clk);
                #1;
            end
            start = (c == 0) || (c == err_at);
            beats = (c == 0) ? CW'(req) : CW'($urandom);
            case (vmode)
                0: din_valid = 1'b1;
                1: din_valid = (c % 2 == 1);
                default: din_valid = ($urandom_range(0, 99) < 60);
            endcase
            din_data = src_d[(idx < 16) ? idx : 15];
            din_mask = src_m[(idx < 16) ? idx : 15];
            case (rmode)
                0: app_wdf_rdy = 1'b1;
                1: app_wdf_rdy = !(c >= 3 && c <= 5);
                default: app_wdf_rdy = ($urandom_range(0, 99) < 70);
            endcase
            #1;
            if (c > 0) begin
                if (din_ready) begin
                    r_rdy_cnt++;
                    if (r_rdy_first < 0) r_rdy_first = c;
                end
                if (din_valid && din_ready) begin
                    r_accepts++;
                    idx++;
                end
                if (pw && !prdy && (wren !== pw || wend !== pe || wdata !== pd || wmask !== pm))
                    r_hold_errs++;
                if (wren && !app_wdf_rdy && din_ready) r_hold_errs++;
                if (wren && !pw) r_wren_pulses++;
                if (wren && r_first_wren < 0) r_first_wren = c;
                if (wren && app_wdf_rdy) begin
                    if (r_xfers >= 16 || wdata !== src_d[r_xfers] || wmask !== src_m[r_xfers])
                        r_data_errs++;
                    if (wend) begin
                        r_ends++;
                        if (r_xfers == r_n - 1) r_end_last++;
                    end
                    r_xfers++;
                end
                if (start_err) begin
                    r_serr_cnt++;
                    r_serr_cyc = c;
                end
                if (!done && busy !== 1'b1) r_busy_bad++;
                if (done && busy !== 1'b0) r_busy_bad++;
            end
            pw = wren; pe = wend; pd = wdata; pm = wmask; prdy = app_wdf_rdy;
            if (c > 0 && done) begin
                r_done_cyc = c;
                break;
            end
        end
        if (r_done_cyc < 0) r_timeout = 1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b1;
        din_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({wren, wend, wdata, wmask} !== '0) begin
            fails++;
            $display("FAIL reset_wdf: got wren=%0b end=%0b data=%h mask=%h, expected all 0", wren, wend, wdata, wmask);
        end
        checks++;
        if ({busy, done, start_err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_status: got busy/done/start_err=%b, expected 000", {busy, done, start_err});
        end
        checks++;
        if (din_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_din_ready: got %b, expected 0", din_ready);
        end
        start = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_single_beat();
        run_burst(1, 0, 0, -1, 1, 0);
        checks++;
        if (r_first_wren != 2 || r_xfers != 1) begin
            fails++;
            $display("FAIL single_wren: got first=%0d xfers=%0d, expected 2 and 1", r_first_wren, r_xfers);
        end
        checks++;
        if (r_ends != 1 || r_end_last != 1 || r_data_errs != 0) begin
            fails++;
            $display("FAIL single_end_data: got ends=%0d last=%0d data_errs=%0d, expected 1 1 0", r_ends, r_end_last, r_data_errs);
        end
        checks++;
        if (r_done_cyc != 3 || r_busy_bad != 0) begin
            fails++;
            $display("FAIL single_done: got done cycle %0d busy_bad=%0d, expected 3 and 0", r_done_cyc, r_busy_bad);
        end
        checks++;
        if (r_rdy_cnt != 1 || r_rdy_first != 1) begin
            fails++;
            $display("FAIL single_din_ready: got count=%0d first=%0d, expected 1 and 1", r_rdy_cnt, r_rdy_first);
        end
    endtask

    task automatic test_full_burst();
        run_burst(8, 0, 0, -1, 1, 0);
        checks++;
        if (r_first_wren != 2 || r_wren_pulses != 1 || r_xfers != 8) begin
            fails++;
            $display("FAIL full_wren: got first=%0d pulses=%0d xfers=%0d, expected 2 1 8", r_first_wren, r_wren_pulses, r_xfers);
        end
        checks++;
        if (r_data_errs != 0 || r_ends != 1 || r_end_last != 1) begin
            fails++;
            $display("FAIL full_order_end: got data_errs=%0d ends=%0d last=%0d, expected 0 1 1", r_data_errs, r_ends, r_end_last);
        end
        checks++;
        if (r_done_cyc != 10) begin
            fails++;
            $display("FAIL full_done: got cycle %0d, expected 10", r_done_cyc);
        end
    endtask

    task automatic test_backpressure();
        run_burst(4, 0, 1, -1, 0, 0);
        checks++;
        if (r_hold_errs != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d stability/din_ready violations, expected 0", r_hold_errs);
        end
        checks++;
        if (r_xfers != 4 || r_accepts != 4 || r_data_errs != 0) begin
            fails++;
            $display("FAIL bp_beats: got xfers=%0d accepts=%0d data_errs=%0d, expected 4 4 0", r_xfers, r_accepts, r_data_errs);
        end
        checks++;
        if (r_ends != 1 || r_end_last != 1 || r_done_cyc != 9) begin
            fails++;
            $display("FAIL bp_end_done: got ends=%0d last=%0d done=%0d, expected 1 1 9", r_ends, r_end_last, r_done_cyc);
        end
    endtask

    task automatic test_upstream_stall();
        run_burst(4, 1, 0, -1, 0, 0);
        checks++;
        if (r_wren_pulses != 4 || r_xfers != 4 || r_data_errs != 0) begin
            fails++;
            $display("FAIL stall_pulses: got pulses=%0d xfers=%0d data_errs=%0d, expected 4 4 0", r_wren_pulses, r_xfers, r_data_errs);
        end
        checks++;
        if (r_ends != 1 || r_end_last != 1 || r_done_cyc != 9) begin
            fails++;
            $display("FAIL stall_end_done: got ends=%0d last=%0d done=%0d, expected 1 1 9", r_ends, r_end_last, r_done_cyc);
        end
    endtask

    task automatic test_clamp_zero();
        run_burst(0, 0, 0, -1, 0, 0);
        checks++;
        if (r_xfers != 1 || r_accepts != 1 || r_end_last != 1 || r_timeout) begin
            fails++;
            $display("FAIL zero_beats: got xfers=%0d accepts=%0d end_last=%0d, expected 1 1 1", r_xfers, r_accepts, r_end_last);
        end
        run_burst(15, 2, 2, -1, 0, 0);
        checks++;
        if (r_xfers != 8 || r_accepts != 8 || r_ends != 1 || r_end_last != 1 || r_data_errs != 0) begin
            fails++;
            $display("FAIL clamp_beats: got xfers=%0d accepts=%0d ends=%0d data_errs=%0d, expected 8 8 1 0", r_xfers, r_accepts, r_ends, r_data_errs);
        end
    endtask

    task automatic test_start_busy();
        run_burst(4, 0, 0, 3, 0, 0);
        checks++;
        if (r_serr_cnt != 1 || r_serr_cyc != 4) begin
            fails++;
            $display("FAIL start_err_pulse: got count=%0d cycle=%0d, expected 1 at 4", r_serr_cnt, r_serr_cyc);
        end
        checks++;
        if (r_xfers != 4 || r_data_errs != 0 || r_done_cyc != 6 || r_end_last != 1) begin
            fails++;
            $display("FAIL start_busy_burst: got xfers=%0d data_errs=%0d done=%0d, expected 4 0 6", r_xfers, r_data_errs, r_done_cyc);
        end
    endtask

    task automatic test_reset_mid_burst();
        int late_done;
        int late_wren;
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0);
            beats = CW'(4);
            din_valid = 1'b1;
            din_data = {$urandom, $urandom, $urandom, $urandom};
            din_mask = MW'($urandom);
            app_wdf_rdy = 1'b1;
            rstn = (c != 4);
            #1;
        end
        checks++;
        if (wren !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_inflight: got wren=%b busy=%b before reset, expected 1 1", wren, busy);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        checks++;
        if ({wren, wend, wdata, wmask, busy, done, start_err, din_ready} !== '0) begin
            fails++;
            $display("FAIL midrst_clear: got wren=%b end=%b busy=%b done=%b din_ready=%b data=%h, expected all 0",
                     wren, wend, busy, done, din_ready, wdata);
        end
        late_done = 0;
        late_wren = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #2;
            if (done) late_done++;
            if (wren) late_wren++;
        end
        checks++;
        if (late_done != 0 || late_wren != 0) begin
            fails++;
            $display("FAIL midrst_abandon: got done=%0d wren=%0d after reset, expected 0 0", late_done, late_wren);
        end
        run_burst(3, 0, 0, -1, 1, 0);
        checks++;
        if (r_xfers != 3 || r_data_errs != 0 || r_done_cyc != 5 || r_end_last != 1) begin
            fails++;
            $display("FAIL midrst_fresh: got xfers=%0d data_errs=%0d done=%0d, expected 3 0 5", r_xfers, r_data_errs, r_done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        run_burst(2, 0, 0, -1, 1, 0);
        checks++;
        if (r_done_cyc != 4 || r_xfers != 2) begin
            fails++;
            $display("FAIL b2b_first: got done=%0d xfers=%0d, expected 4 2", r_done_cyc, r_xfers);
        end
        // Start is raised in the cycle done is high.
        start = 1'b1;
        beats = CW'(3);
        run_burst(3, 0, 0, -1, 0, 1);
        checks++;
        if (r_serr_cnt != 0 || r_first_wren != 2 || r_done_cyc != 5 || r_xfers != 3 || r_data_errs != 0) begin
            fails++;
            $display("FAIL b2b_second: got start_err=%0d first=%0d done=%0d xfers=%0d, expected 0 2 5 3",
                     r_serr_cnt, r_first_wren, r_done_cyc, r_xfers);
        end
    endtask

    task automatic test_random();
        int req;
        for (int t = 0; t < 8; t++) begin
            req = $urandom_range(0, 15);
            run_burst(req, 2, 2, -1, 0, 0);
            checks++;
            if (r_timeout || r_xfers != r_n || r_accepts != r_n || r_data_errs != 0 || r_hold_errs != 0 ||
                r_ends != 1 || r_end_last != 1 || r_busy_bad != 0) begin
                fails++;
                $display("FAIL random_burst: req=%0d got xfers=%0d accepts=%0d data_errs=%0d hold=%0d ends=%0d timeout=%0b, expected %0d beats clean",
                         req, r_xfers, r_accepts, r_data_errs, r_hold_errs, r_ends, r_timeout, r_n);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        beats = '0;
        din_valid = 1'b0;
        din_data = '0;
        din_mask = '0;
        app_wdf_rdy = 1'b1;
        test_reset();
        test_single_beat();
        test_full_burst();
        test_backpressure();
        test_upstream_stall();
        test_clamp_zero();
        test_start_busy();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
